// File: rtl/mem_pkg.sv
// Shared definitions for the data-side memory access path: default widths,
// memory region codes and the access-controller state encoding.
package mem_pkg;

  localparam int ADDR_W_DEFAULT = 12;
  localparam int DATA_W_DEFAULT = 16;

  // Region decode on addr[11:10] is done by the memory; codes kept here for reference users.
  localparam logic [1:0] REGION_INSTR = 2'b00;
  localparam logic [1:0] REGION_D1    = 2'b01;
  localparam logic [1:0] REGION_D2    = 2'b10;
  localparam logic [1:0] REGION_D3    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR,
    ST_RESP
  } mau_state_t;

  function automatic logic misaligned(input logic addr_lsb, input bit check_align);
    return check_align && addr_lsb;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core-side request/response channels of the memory access unit.
interface mem_access_unit_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Data-side memory access controller: one word request at a time, sequences the
// shared tri-state bus to the memory and returns load data or a store acknowledge.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  core,
  output logic [ADDR_W-1:0] address_bus,
  inout  wire  [DATA_W-1:0] data_bus,
  output logic              write_mode,
  output logic              busy
);

  mau_state_t        state_q;
  logic [ADDR_W-1:0] address_bus_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_mode_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              resp_valid_q;

  // NOTE: every register below is written with <= so all updates see the
  // pre-edge values; reset is sampled on the clock edge, not asynchronously.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      address_bus_q <= '0;
      wdata_q       <= '0;
      write_mode_q  <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      resp_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (core.req_valid) begin
            wdata_q <= core.req_wdata;
            if (misaligned(core.req_addr[0], CHECK_ALIGN)) begin
              // Error path leaves the bus untouched and answers immediately.
              err_q        <= 1'b1;
              rdata_q      <= '0;
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end else begin
              address_bus_q <= core.req_addr;
              err_q         <= 1'b0;
              if (core.req_write) begin
                write_mode_q <= 1'b1;
                state_q      <= ST_WR;
              end else begin
                state_q <= ST_RD_ADDR;
              end
            end
          end
        end
        ST_RD_ADDR: begin
          state_q <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          rdata_q      <= data_bus;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_WR: begin
          write_mode_q <= 1'b0;
          rdata_q      <= '0;
          err_q        <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (core.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: the output enable comes straight from the write_mode register, so the
  // memory (which drives when write_mode=0) and this unit swap on the same edge.
  assign data_bus = write_mode_q ? wdata_q : {DATA_W{1'bz}};

  assign address_bus     = address_bus_q;
  assign write_mode      = write_mode_q;
  assign busy            = (state_q != ST_IDLE);
  assign core.req_ready  = (state_q == ST_IDLE) && !rst;
  assign core.resp_valid = resp_valid_q;
  assign core.resp_rdata = rdata_q;
  assign core.resp_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: bus-level memory device, a
// transaction-level expectation model checked every cycle, and directed vectors.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic [11:0] address_bus;
  wire  [15:0] data_bus;
  logic        write_mode;
  logic        busy;

  mem_access_unit_if #(.ADDR_W(12), .DATA_W(16)) bus_if ();

  mem_access_unit #(.ADDR_W(12), .DATA_W(16), .CHECK_ALIGN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .core        (bus_if),
    .address_bus (address_bus),
    .data_bus    (data_bus),
    .write_mode  (write_mode),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory device: registered read, drives the bus whenever write_mode is low.
  logic [15:0] ram [0:2047];
  logic [15:0] mem_rd_q;
  assign data_bus = write_mode ? 16'bz : mem_rd_q;
  always @(posedge clk) begin
    if (write_mode) ram[address_bus[11:1]] <= data_bus;
    mem_rd_q <= ram[address_bus[11:1]];
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: word memory plus at most one outstanding access.
  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [15:0] wd;
    logic [15:0] rd;
    logic        err;
    int          lat;
  } txn_t;

  logic [15:0] model_mem [0:2047];
  txn_t        pend;
  bit          pend_v   = 1'b0;
  int          pend_age = 0;
  logic        rst_q_tb = 1'b1;
  bit          armed    = 1'b0;

  always @(posedge clk) begin
    rst_q_tb <= rst;
    if (rst) armed <= 1'b1;
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram[i]       = 16'h0000;
      model_mem[i] = 16'h0000;
    end
    ram[12'hFFC >> 1] = 16'hABCD; model_mem[12'hFFC >> 1] = 16'hABCD;
    ram[0]            = 16'hFFFF; model_mem[0]            = 16'hFFFF;
    ram[1]            = 16'hEEEE; model_mem[1]            = 16'hEEEE;
  end

  // Compare process: checks every DUT output against the model on each negedge.
  initial begin
    bit   was_empty;
    bit   v_exp;
    bit   wm_exp;
    forever begin
      @(negedge clk);
      if (armed) begin
        if (rst_q_tb) pend_v = 1'b0;
        if (pend_v) pend_age++;
        v_exp  = pend_v && (pend_age >= pend.lat);
        wm_exp = pend_v && pend.wr && !pend.err && (pend_age == 1);
        check("resp_valid", {31'b0, bus_if.resp_valid}, {31'b0, v_exp});
        check("req_ready", {31'b0, bus_if.req_ready}, {31'b0, !rst && !pend_v});
        check("busy", {31'b0, busy}, {31'b0, pend_v});
        check("write_mode", {31'b0, write_mode}, {31'b0, wm_exp});
        if (v_exp) begin
          check("resp_rdata", {16'b0, bus_if.resp_rdata}, {16'b0, pend.rd});
          check("resp_err", {31'b0, bus_if.resp_err}, {31'b0, pend.err});
        end
        if (pend_v && !pend.err && pend_age < pend.lat)
          check("address_bus", {20'b0, address_bus}, {20'b0, pend.addr});
        if (wm_exp) check("data_bus_wr", {16'b0, data_bus}, {16'b0, pend.wd});
        if (!rst_q_tb) check("data_bus_known", {31'b0, $isunknown(data_bus)}, 32'd0);
        was_empty = !pend_v;
        if (v_exp && bus_if.resp_ready && !rst) pend_v = 1'b0;
        if (was_empty && bus_if.req_valid && !rst) begin
          pend.wr   = bus_if.req_write;
          pend.addr = bus_if.req_addr;
          pend.wd   = bus_if.req_wdata;
          pend.err  = bus_if.req_addr[0];
          if (pend.err) begin
            pend.rd = 16'h0; pend.lat = 1;
          end else if (pend.wr) begin
            model_mem[pend.addr >> 1] = pend.wd;
            pend.rd = 16'h0; pend.lat = 2;
          end else begin
            pend.rd = model_mem[pend.addr >> 1]; pend.lat = 3;
          end
          pend_v   = 1'b1;
          pend_age = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request, counts negedges until acceptance and edges to response.
  task automatic run_req(input logic wr, input logic [11:0] addr, input logic [15:0] wd,
                         input int exp_lat, input logic [15:0] exp_rd, input logic exp_err,
                         input string name, output int waits);
    int lat;
    bit got;
    bus_if.req_write = wr;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = wd;
    bus_if.req_valid = 1'b1;
    waits = 0;
    got   = 1'b0;
    while (!got && waits < 20) begin
      @(negedge clk);
      waits++;
      if (bus_if.req_ready) got = 1'b1;
    end
    if (!got) begin
      check({name, "_accept"}, {31'b0, bus_if.req_ready}, 32'd1);
      bus_if.req_valid = 1'b0;
      return;
    end
    step();
    bus_if.req_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    while (!got && lat <= 20) begin
      @(negedge clk);
      if (bus_if.resp_valid) got = 1'b1;
      else lat++;
    end
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_rdata"}, {16'b0, bus_if.resp_rdata}, {16'b0, exp_rd});
    check({name, "_err"}, {31'b0, bus_if.resp_err}, {31'b0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    rst               = 1'b1;
    bus_if.req_valid  = 1'b0;
    bus_if.req_write  = 1'b0;
    bus_if.req_addr   = '0;
    bus_if.req_wdata  = '0;
    bus_if.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'b0, bus_if.req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, bus_if.resp_valid}, 32'd0);
    check("rst_rdata", {16'b0, bus_if.resp_rdata}, 32'd0);
    check("rst_err", {31'b0, bus_if.resp_err}, 32'd0);
    check("rst_address_bus", {20'b0, address_bus}, 32'd0);
    check("rst_write_mode", {31'b0, write_mode}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    step();
    rst = 1'b0;

    run_req(1'b0, 12'hFFC, 16'h0, 3, 16'hABCD, 1'b0, "ld_ffc", waits);
    step();

    run_req(1'b0, 12'h000, 16'h0, 3, 16'hFFFF, 1'b0, "ld_000", waits);
    step();
    run_req(1'b0, 12'h002, 16'h0, 3, 16'hEEEE, 1'b0, "ld_002", waits);
    check("ld_002_accept_wait", waits, 1);
    step();

    run_req(1'b1, 12'h402, 16'h1234, 2, 16'h0000, 1'b0, "st_402", waits);
    step();
    run_req(1'b0, 12'h402, 16'h0, 3, 16'h1234, 1'b0, "ld_402", waits);
    step();

    run_req(1'b0, 12'h003, 16'h0, 1, 16'h0000, 1'b1, "ld_003_misaligned", waits);
    check("misaligned_addr_hold", {20'b0, address_bus}, 32'h402);
    check("misaligned_write_mode", {31'b0, write_mode}, 32'd0);
    step();

    bus_if.resp_ready = 1'b0;
    run_req(1'b0, 12'hFFC, 16'h0, 3, 16'hABCD, 1'b0, "stall_ld_ffc", waits);
    step();
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b1;
    bus_if.req_addr  = 12'h000;
    bus_if.req_wdata = 16'h0BAD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, bus_if.resp_valid}, 32'd1);
      check("stall_rdata", {16'b0, bus_if.resp_rdata}, 32'hABCD);
      check("stall_req_ready", {31'b0, bus_if.req_ready}, 32'd0);
      step();
    end
    bus_if.req_valid  = 1'b0;
    bus_if.resp_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    check("stall_release_busy", {31'b0, busy}, 32'd0);
    check("stall_release_ready", {31'b0, bus_if.req_ready}, 32'd1);
    step();

    bus_if.req_write = 1'b0;
    bus_if.req_addr  = 12'hFFC;
    bus_if.req_valid = 1'b1;
    @(negedge clk);
    step();
    bus_if.req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_valid", {31'b0, bus_if.resp_valid}, 32'd0);
      check("rst_mid_busy", {31'b0, busy}, 32'd0);
      check("rst_mid_write_mode", {31'b0, write_mode}, 32'd0);
      step();
    end
    run_req(1'b0, 12'hFFC, 16'h0, 3, 16'hABCD, 1'b0, "ld_ffc_after_rst", waits);
    step();

    bus_if.req_write = 1'b1;
    bus_if.req_addr  = 12'h004;
    bus_if.req_wdata = 16'h5A5A;
    bus_if.req_valid = 1'b1;
    @(negedge clk);
    step();
    bus_if.req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_wr_write_mode", {31'b0, write_mode}, 32'd0);
    step();
    run_req(1'b0, 12'h004, 16'h0, 3, 16'h5A5A, 1'b0, "ld_004_after_wr_rst", waits);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
